ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter. It sends one command byte, such as set-LEDs (0xED) or reset (0xFF), from the system to the keyboard over the open-collector PS/2 clock and data lines. It is the outbound counterpart of the receive path that feeds the keyboard buffer. It shares the pad-level lines with the receiver, and drives them only through active-high pull-low enables.

---
 rtl/ps2_host_tx.sv | 133 +++++++++++++
 tb/tb_ps2_host_tx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command byte transmitter driving open-collector pull-low enables
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       send,
  input  logic [7:0] tx_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic       timeout
);
  localparam int MAXC = TIMEOUT_CYCLES > INHIBIT_CYCLES ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, BITS, ACK, WAIT_IDLE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] idx, idx_n;
  logic [7:0] data_r, data_n;
  logic nack_f, nack_f_n;
  logic clk_s1, clk_s2, clk_prev, data_s1, data_s2;
  logic fall, data_oe_n, done_n, nack_n, to_n;
  assign fall = clk_prev & ~clk_s2;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {clk_s1, clk_s2, clk_prev, data_s1, data_s2} <= 5'b11111;
    end else begin
      {clk_s1, clk_s2, clk_prev} <= {ps2_clk_in, clk_s1, clk_s2};
      {data_s1, data_s2} <= {ps2_data_in, data_s1};
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      data_r <= '0;
      nack_f <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      nack <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      data_r <= data_n;
      nack_f <= nack_f_n;
      ps2_clk_oe <= state_n == INHIBIT;
      ps2_data_oe <= data_oe_n;
      busy <= state_n != IDLE;
      done <= done_n;
      nack <= nack_n;
      timeout <= to_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    idx_n = idx;
    data_n = data_r;
    nack_f_n = nack_f;
    data_oe_n = ps2_data_oe;
    done_n = 1'b0;
    nack_n = 1'b0;
    to_n = 1'b0;
    if (state == IDLE) begin
      data_oe_n = 1'b0;
      if (send) begin
        state_n = INHIBIT;
        data_n = tx_data;
        cnt_n = INH_LAST;
        nack_f_n = 1'b0;
        data_oe_n = INH_LAST == '0;
      end
    end else if (state == INHIBIT) begin
      cnt_n = cnt - CW'(1);
      data_oe_n = cnt == CW'(1);
      if (cnt == '0) begin
        state_n = REQ;
        cnt_n = '0;
        idx_n = '0;
        data_oe_n = 1'b1;
      end
    end else if (cnt == TO_LAST) begin
      state_n = IDLE;
      cnt_n = '0;
      data_oe_n = 1'b0;
      done_n = 1'b1;
      to_n = 1'b1;
    end else begin
      cnt_n = cnt + CW'(1);
      if (state == REQ) begin
        data_oe_n = 1'b1;
        if (fall) begin
          data_oe_n = ~data_r[0];
          idx_n = 4'd1;
          state_n = BITS;
        end
      end else if (state == BITS) begin
        if (fall) begin
          data_oe_n = idx < 4'd8 ? ~data_r[idx[2:0]] : idx == 4'd8 ? ^data_r : 1'b0;
          idx_n = idx == 4'hf ? idx : idx + 4'd1;
          state_n = idx >= 4'd9 ? ACK : BITS;
        end
      end else if (state == ACK) begin
        data_oe_n = 1'b0;
        if (fall) begin
          nack_f_n = data_s2;
          state_n = WAIT_IDLE;
        end
      end else begin
        data_oe_n = 1'b0;
        if (clk_s2 && data_s2) begin
          state_n = IDLE;
          cnt_n = '0;
          done_n = 1'b1;
          nack_n = nack_f;
        end
      end
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed self-checking bench for ps2_host_tx with a simple PS/2 device model
module tb_ps2_host_tx;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic send = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  logic ps2_clk_in, ps2_data_in;
  logic ps2_clk_oe, ps2_data_oe, busy, done, nack, timeout;
  int n_chk = 0;
  int n_fail = 0;
  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);
  always #5 clk = ~clk;
  ps2_host_tx #(.INHIBIT_CYCLES(10), .TIMEOUT_CYCLES(1000)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .send(send),
    .tx_data(tx_data),
    .ps2_clk_in(ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy(busy),
    .done(done),
    .nack(nack),
    .timeout(timeout)
  );
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_byte(input logic [7:0] b);
    int n = 1;
    @(negedge clk);
    send = 1'b1;
    tx_data = b;
    @(negedge clk);
    send = 1'b0;
    tx_data = ~b;
    while (ps2_clk_oe && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (ps2_clk_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL send_%h: ps2_clk_oe still %b after %0d cycles, expected release", b, ps2_clk_oe, n);
    end
  endtask
  task automatic dev_frame(input logic [9:0] exp, input bit ack, input bit ign, input int last, input string name);
    for (int k = 1; k <= last; k++) begin
      if (k == 11) dev_data_low = ack;
      dev_clk_low = 1'b0;
      wait_cycles(20);
      dev_clk_low = 1'b1;
      wait_cycles(10);
      if (k <= 10) begin
        n_chk++;
        if (ps2_data_oe !== exp[k-1]) begin
          n_fail++;
          $display("FAIL %s fall %0d: ps2_data_oe=%b expected %b", name, k, ps2_data_oe, exp[k-1]);
        end
      end
      if (ign && k == 5) begin
        send = 1'b1;
        tx_data = 8'h55;
        @(negedge clk);
        send = 1'b0;
        wait_cycles(9);
      end else begin
        wait_cycles(10);
      end
    end
    if (last == 11) begin
      dev_clk_low = 1'b0;
      dev_data_low = 1'b0;
    end
  endtask
  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done: done=%b after %0d cycles, expected 1", name, done, n);
    end
  endtask
  task automatic test_reset();
    wait_cycles(3);
    n_chk++;
    if ({ps2_clk_oe, ps2_data_oe, busy, done, nack, timeout} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 000000", {ps2_clk_oe, ps2_data_oe, busy, done, nack, timeout});
    end
    reset_n = 1'b1;
    wait_cycles(3);
    n_chk++;
    if ({ps2_clk_oe, ps2_data_oe, busy, done, nack, timeout} !== 6'b0) begin
      n_fail++;
      $display("FAIL idle_outputs: got %b expected 000000", {ps2_clk_oe, ps2_data_oe, busy, done, nack, timeout});
    end
  endtask
  task automatic test_inhibit();
    int hi = 0;
    int rise = 0;
    int i = 1;
    @(negedge clk);
    send = 1'b1;
    tx_data = 8'hED;
    @(negedge clk);
    send = 1'b0;
    tx_data = 8'h00;
    while (ps2_clk_oe && i < 40) begin
      if (ps2_data_oe && rise == 0) rise = i;
      hi++;
      i++;
      @(negedge clk);
    end
    n_chk++;
    if (hi != 10) begin
      n_fail++;
      $display("FAIL inhibit_len: ps2_clk_oe high %0d cycles, expected 10", hi);
    end
    n_chk++;
    if (rise != 10) begin
      n_fail++;
      $display("FAIL start_bit_cycle: ps2_data_oe rose on cycle %0d, expected 10", rise);
    end
    n_chk++;
    if (i != 11 || ps2_data_oe !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL req_entry: cycle=%0d data_oe=%b busy=%b, expected 11 1 1", i, ps2_data_oe, busy);
    end
  endtask
  task automatic test_normal();
    dev_frame(10'h012, 1'b1, 1'b0, 11, "ed");
    wait_done("ed");
    n_chk++;
    if ({nack, timeout, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL ed_flags: nack/timeout/busy=%b expected 000", {nack, timeout, busy});
    end
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL ed_done_pulse: done=%b one cycle later, expected 0", done);
    end
  endtask
  task automatic test_nack();
    send_byte(8'hF4);
    dev_frame(10'h10B, 1'b0, 1'b0, 11, "nack_f4");
    wait_done("nack");
    n_chk++;
    if ({nack, timeout, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL nack_flags: nack/timeout/busy=%b expected 100", {nack, timeout, busy});
    end
  endtask
  task automatic test_ignored_send();
    int extra = 0;
    send_byte(8'hFF);
    dev_frame(10'h000, 1'b1, 1'b1, 11, "ff");
    wait_done("ff");
    n_chk++;
    if ({nack, timeout} !== 2'b00) begin
      n_fail++;
      $display("FAIL ff_flags: nack/timeout=%b expected 00", {nack, timeout});
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    n_chk++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL no_second_transfer: busy/done seen %0d cycles, expected 0", extra);
    end
  endtask
  task automatic test_timeout();
    int j = 0;
    send_byte(8'h00);
    while (done !== 1'b1 && j < 1100) begin
      @(negedge clk);
      j++;
    end
    n_chk++;
    if (j != 1000) begin
      n_fail++;
      $display("FAIL timeout_cycle: done after %0d cycles from REQ, expected 1000", j);
    end
    n_chk++;
    if ({done, timeout, nack, ps2_clk_oe, ps2_data_oe, busy} !== 6'b110000) begin
      n_fail++;
      $display("FAIL timeout_flags: done/to/nack/clk_oe/data_oe/busy=%b expected 110000",
               {done, timeout, nack, ps2_clk_oe, ps2_data_oe, busy});
    end
    @(negedge clk);
    n_chk++;
    if ({done, timeout, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_after_timeout: done/to/busy=%b expected 000", {done, timeout, busy});
    end
  endtask
  task automatic test_reset_mid();
    send_byte(8'hED);
    dev_frame(10'h012, 1'b1, 1'b0, 5, "pre_rst");
    n_chk++;
    if (ps2_data_oe !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_d4: ps2_data_oe=%b expected 1", ps2_data_oe);
    end
    #2 reset_n = 1'b0;
    #1;
    n_chk++;
    if ({ps2_clk_oe, ps2_data_oe, busy, done, nack, timeout} !== 6'b0) begin
      n_fail++;
      $display("FAIL async_reset: outputs=%b expected 000000", {ps2_clk_oe, ps2_data_oe, busy, done, nack, timeout});
    end
    dev_clk_low = 1'b0;
    wait_cycles(3);
    reset_n = 1'b1;
    wait_cycles(2);
    send_byte(8'hF4);
    dev_frame(10'h10B, 1'b1, 1'b0, 11, "f4");
    wait_done("f4");
    n_chk++;
    if ({nack, timeout, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL f4_flags: nack/timeout/busy=%b expected 000", {nack, timeout, busy});
    end
  endtask
  initial begin
    test_reset();
    test_inhibit();
    test_normal();
    test_nack();
    test_ignored_send();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
